// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - sequencer handshake/strobe bundle; SEQ_PERFCOUNT_EN adds retired/stall_cycles
interface multicycle_sequencer_if #(
  parameter int CONTROLSIZE = 8
);
  logic                   run;
  logic [CONTROLSIZE-1:0] control;
  logic                   imem_req;
  logic                   imem_ready;
  logic                   dmem_req;
  logic                   dmem_we;
  logic                   dmem_ready;
  logic                   ir_write;
  logic                   pc_write;
  logic                   reg_we;
  logic                   flags_we;
  logic [2:0]             state;
  logic                   busy;
  logic                   fault;
`ifdef SEQ_PERFCOUNT_EN
  logic [31:0]            retired;
  logic [31:0]            stall_cycles;

  modport slave (
    input  run, control, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_we, flags_we,
    output state, busy, fault, retired, stall_cycles
  );

  modport master (
    output run, control, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_we, flags_we,
    input  state, busy, fault, retired, stall_cycles
  );
`else
  modport slave (
    input  run, control, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_we, flags_we,
    output state, busy, fault
  );

  modport master (
    output run, control, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_we, flags_we,
    input  state, busy, fault
  );
`endif
endinterface

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - LEGv8 multicycle sequencer with memory watchdog
// SEQ_PERFCOUNT_EN builds the retired/stall_cycles counters.
module multicycle_sequencer #(
  parameter int TIMEOUT  = 16,
  parameter int REGWRITE = 0,
  parameter int MEMREAD  = 1,
  parameter int MEMWRITE = 2,
  parameter int SETFLAGS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] TIMEOUT_W = WW'(TIMEOUT);

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [WW-1:0] wait_inc;
  logic          regwrite_q, regwrite_d;
  logic          memread_q, memread_d;
  logic          memwrite_q, memwrite_d;
  logic          setflags_q, setflags_d;
  logic          mem_wait;
  logic          expire;

  // A wait cycle is a requesting cycle whose ready is still low.
  assign mem_wait = ((state_q == S_FETCH) && !bus.imem_ready) ||
                    ((state_q == S_MEM) && !bus.dmem_ready);
  assign wait_inc = wait_q + WW'(1);
  assign expire   = (TIMEOUT != 0) && mem_wait && (wait_inc == TIMEOUT_W);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.run) state_d = S_FETCH;
      S_FETCH: begin
        if (expire)              state_d = S_FAULT;
        else if (bus.imem_ready) state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (memread_q || memwrite_q) ? S_MEM : S_WB;
      S_MEM: begin
        if (expire)              state_d = S_FAULT;
        else if (bus.dmem_ready) state_d = S_WB;
      end
      S_WB:     state_d = bus.run ? S_FETCH : S_IDLE;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
      wait_d = '0;
    end else if (mem_wait) begin
      wait_d = wait_inc;
    end
  end

  // The decode path is combinational from the IR, so DECODE sees the new instruction.
  always_comb begin
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    setflags_d = setflags_q;
    if (state_q == S_DECODE) begin
      regwrite_d = bus.control[REGWRITE];
      memread_d  = bus.control[MEMREAD];
      memwrite_d = bus.control[MEMWRITE];
      setflags_d = bus.control[SETFLAGS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      setflags_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      setflags_q <= setflags_d;
    end
  end

  // Requests and strobes follow the registered state; only ir_write sees imem_ready.
  always_comb begin
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    bus.ir_write = 1'b0;
    bus.pc_write = 1'b0;
    bus.reg_we   = 1'b0;
    bus.flags_we = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_write = bus.imem_ready;
      end
      S_EXEC:  bus.flags_we = setflags_q;
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = memwrite_q;
      end
      S_WB: begin
        bus.pc_write = 1'b1;
        bus.reg_we   = regwrite_q;
      end
      default: ;
    endcase
  end

  assign bus.state = state_q;
  assign bus.busy  = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign bus.fault = (state_q == S_FAULT);

`ifdef SEQ_PERFCOUNT_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    retired_d = retired_q;
    stall_d   = stall_q;
    if (state_q == S_WB) retired_d = retired_q + 32'd1;
    if (mem_wait)        stall_d   = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.retired      = retired_q;
  assign bus.stall_cycles = stall_q;
`endif

endmodule
